// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and imem fetch front end feeding decode through a prefetch FIFO
// Ports: clk/reset (sync, active high); imem_req_valid/ready + imem_addr issue word fetches;
// imem_resp_valid/imem_rdata return the single outstanding word; redirect_valid/redirect_pc
// flush and restart fetch; instr_valid/ready + instr/instr_pc present the FIFO head to decode;
// fetch_misaligned flags a redirect target with nonzero low bits when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);

    logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d, drop_q, drop_d, mis_q, mis_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_in_q [DEPTH];
    logic          push, pop, accept;

    assign instr_valid      = cnt_q != '0;
    assign instr            = instr_valid ? fifo_in_q[rd_q] : '0;
    assign instr_pc         = instr_valid ? fifo_pc_q[rd_q] : '0;
    assign imem_addr        = pc_q;
    assign fetch_misaligned = mis_q;

    always_comb begin
        push           = imem_resp_valid && outstanding_q && !drop_q && !redirect_valid;
        pop            = instr_valid && instr_ready && !redirect_valid;
        // a request may only go out if the FIFO has room for it after this cycle's push
        imem_req_valid = !reset && !redirect_valid && (!outstanding_q || imem_resp_valid) &&
                         (push ? cnt_q < FULL_M1 : cnt_q < FULL);
        accept         = imem_req_valid && imem_req_ready;
        pc_d           = redirect_valid ? (redirect_pc & ~32'h3) : accept ? pc_q + 32'd4 : pc_q;
        req_pc_d       = accept ? pc_q : req_pc_q;
        outstanding_d  = accept || (outstanding_q && !imem_resp_valid);
        // a redirect with a request still in flight must swallow its late response
        drop_d         = (redirect_valid ? outstanding_q : drop_q) && !imem_resp_valid;
        wr_d           = redirect_valid ? '0 : push ? wr_q + AW'(1) : wr_q;
        rd_d           = redirect_valid ? '0 : pop ? rd_q + AW'(1) : rd_q;
        cnt_d          = redirect_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef FETCH_ALIGN_CHECK_EN
        mis_d          = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
        mis_d          = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            mis_q         <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            mis_q         <= mis_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_q] <= req_pc_q;
            fifo_in_q[wr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, backpressure, redirect, reset and alignment
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        redirect_valid, instr_valid, instr_ready, fetch_misaligned;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_EXP = 32'd1;
`else
    localparam logic [31:0] MIS_EXP = 32'd0;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0, lat = 1, cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] acc_q[$];
    logic [31:0] pop_q[$];
    logic        s_rv, s_iv, s_mis;
    logic [31:0] s_addr, s_in, s_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: snapshot outputs mid-cycle, then play memory for the next cycle
    task automatic cyc();
        logic acc_now;
        logic [31:0] a;
        @(negedge clk);
        s_rv = imem_req_valid; s_addr = imem_addr; s_iv = instr_valid;
        s_in = instr; s_pc = instr_pc; s_mis = fetch_misaligned;
        acc_now = imem_req_valid && imem_req_ready;
        a = imem_addr;
        if (acc_now) acc_q.push_back(a);
        if (instr_valid && instr_ready && !redirect_valid) begin
            pop_q.push_back(instr_pc);
            chk("word", instr, ~instr_pc);
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (acc_now) begin pend = 1'b1; cnt = lat; paddr = a; end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin imem_resp_valid = 1'b1; imem_rdata = ~paddr; pend = 1'b0; end
        end
    endtask

    task automatic restart(input int l, input logic ir);
        reset = 1'b1; redirect_valid = 1'b0;
        cyc();
        reset = 1'b0; pend = 1'b0; imem_resp_valid = 1'b0; lat = l; instr_ready = ir;
        acc_q.delete(); pop_q.delete();
    endtask

    task automatic wait_pop(input string tag);
        for (int k = 0; k < 40 && pop_q.size() == 0; k++) cyc();
        chk(tag, 32'(pop_q.size() > 0), 32'd1);
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        cyc(); cyc();
        chk("rst_req", 32'(s_rv), 32'd0);
        chk("rst_iv", 32'(s_iv), 32'd0);
        chk("rst_instr", s_in, 32'd0);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_mis", 32'(s_mis), 32'd0);

        restart(1, 1'b1);
        cyc();
        chk("t1_req0", 32'(s_rv), 32'd1);
        chk("t1_addr0", s_addr, 32'h100);
        cyc();
        chk("t1_iv1", 32'(s_iv), 32'd0);
        cyc();
        chk("t1_iv2", 32'(s_iv), 32'd1);
        chk("t1_pc2", s_pc, 32'h100);
        repeat (3) cyc();
        for (int i = 0; i < 3; i++) chk("t1_addr", acc_q[i], 32'h100 + 32'(4 * i));
        for (int i = 0; i < 3; i++) chk("t1_ipc", pop_q[i], 32'h100 + 32'(4 * i));

        restart(1, 1'b0);
        repeat (10) cyc();
        chk("t2_nacc", 32'(acc_q.size()), 32'd2);
        chk("t2_rv", 32'(s_rv), 32'd0);
        chk("t2_iv", 32'(s_iv), 32'd1);
        chk("t2_pc", s_pc, 32'h100);
        chk("t2_npop", 32'(pop_q.size()), 32'd0);
        instr_ready = 1'b1;
        repeat (8) cyc();
        chk("t2_ndrain", 32'(pop_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_drain", pop_q[i], 32'h100 + 32'(4 * i));

        restart(3, 1'b1);
        for (int k = 0; k < 30 && acc_q.size() < 3; k++) cyc();
        chk("t3_acc108", acc_q[2], 32'h108);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        chk("t3_rv_redir", 32'(s_rv), 32'd0);
        redirect_valid = 1'b0; acc_q.delete(); pop_q.delete();
        cyc();
        chk("t3_iv_flush", 32'(s_iv), 32'd0);
        chk("t3_rv_wait", 32'(s_rv), 32'd0);
        wait_pop("t3_wait");
        chk("t3_first_acc", acc_q[0], 32'h200);
        chk("t3_first_pc", pop_q[0], 32'h200);

        restart(1, 1'b1);
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        chk("t4_pc_redir", s_pc, 32'h100);
        redirect_valid = 1'b0; acc_q.delete(); pop_q.delete();
        cyc();
        chk("t4_iv3", 32'(s_iv), 32'd0);
        chk("t4_rv3", 32'(s_rv), 32'd1);
        chk("t4_addr3", s_addr, 32'h200);
        cyc();
        chk("t4_iv4", 32'(s_iv), 32'd0);
        cyc();
        chk("t4_iv5", 32'(s_iv), 32'd1);
        chk("t4_pc5", s_pc, 32'h200);
        chk("t4_in5", s_in, ~32'h200);

        restart(1, 1'b0);
        cyc();
        lat = 3;
        cyc(); cyc();
        chk("t5_iv_pre", 32'(s_iv), 32'd1);
        reset = 1'b1;
        cyc();
        chk("t5_rv_rst", 32'(s_rv), 32'd0);
        reset = 1'b0;
        cyc();
        chk("t5_iv", 32'(s_iv), 32'd0);
        chk("t5_instr", s_in, 32'd0);
        chk("t5_ipc", s_pc, 32'd0);
        chk("t5_mis", 32'(s_mis), 32'd0);
        chk("t5_rv", 32'(s_rv), 32'd1);
        chk("t5_addr", s_addr, 32'h100);
        cyc();
        chk("t5_iv_stale", 32'(s_iv), 32'd0);
        instr_ready = 1'b1; pop_q.delete();
        wait_pop("t5_wait");
        chk("t5_first_pc", pop_q[0], 32'h100);

        restart(1, 1'b1);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h206;
        cyc();
        chk("t6_mis0", 32'(s_mis), 32'd0);
        redirect_valid = 1'b0;
        cyc();
        chk("t6_mis1", 32'(s_mis), MIS_EXP);
        chk("t6_rv", 32'(s_rv), 32'd1);
        chk("t6_addr", s_addr, 32'h204);
        cyc();
        chk("t6_mis2", 32'(s_mis), 32'd0);

        restart(1, 1'b1);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0; acc_q.delete(); pop_q.delete();
        repeat (4) cyc();
        chk("t7_acc0", acc_q[0], 32'hFFFF_FFFC);
        chk("t7_acc1", acc_q[1], 32'h0);
        chk("t7_npop", 32'(pop_q.size()), 32'd2);
        chk("t7_pop0", pop_q[0], 32'hFFFF_FFFC);
        chk("t7_pop1", pop_q[1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
